// File: rtl/instr_loader.sv
// instr_loader: fills an instruction memory from a byte stream, big-endian words
//
// Build option: define LOADER_CHECKSUM_EN to add a running modulo-256 byte sum.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a load (only honoured in IDLE or DONE)
//   len_words  in   words to load, latched on an accepted start
//   byte_in    in   stream byte
//   byte_valid in   byte_in is valid
//   byte_ready out  byte accepted this cycle when byte_valid is also high
//   we         out  one-cycle memory write strobe per word
//   waddr      out  byte address of the written word (low 2 bits zero)
//   wdata      out  assembled word, first byte in [31:24]
//   busy       out  loading or writing
//   done       out  load complete, held until the next accepted start
//   overflow   out  requested length exceeded memory capacity
//   checksum   out  running byte sum since start (zero without the option)
module instr_loader #(
   parameter int ADDRESS_WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-2:0] len_words,
   input  logic [7:0]               byte_in,
   input  logic                     byte_valid,
   output logic                     byte_ready,
   output logic                     we,
   output logic [ADDRESS_WIDTH-1:0] waddr,
   output logic [31:0]              wdata,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow,
   output logic [7:0]               checksum
);
   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   // memory capacity in words, 2^(ADDRESS_WIDTH-2)
   localparam logic [ADDRESS_WIDTH-2:0] CAP = {1'b1, {(ADDRESS_WIDTH-2){1'b0}}};

   state_t                   r_state;
   logic [ADDRESS_WIDTH-2:0] r_len;
   logic [ADDRESS_WIDTH-2:0] r_wcount;
   logic [1:0]               r_bcount;
   logic [31:0]              r_wdata;
   logic [ADDRESS_WIDTH-1:0] r_waddr;
   logic                     r_we;
   logic                     r_done;
   logic                     r_overflow;

   logic                     w_accept;
   logic                     w_start;
   logic                     w_len_hit;
   logic                     w_last_addr;
   logic [ADDRESS_WIDTH-2:0] w_wcount_nxt;

   assign w_accept     = (r_state == LOAD) && byte_valid;
   assign w_start      = ((r_state == IDLE) || (r_state == DONE)) && start;
   assign w_wcount_nxt = r_wcount + 1'b1;
   assign w_len_hit    = w_wcount_nxt == r_len;
   // the word being written sits at the top of memory; never wrap past it
   assign w_last_addr  = &r_waddr[ADDRESS_WIDTH-1:2];

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state    <= IDLE;
         r_len      <= '0;
         r_wcount   <= '0;
         r_bcount   <= '0;
         r_wdata    <= '0;
         r_waddr    <= '0;
         r_we       <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            IDLE, DONE:
               if (start) begin
                  r_len      <= len_words;
                  r_wcount   <= '0;
                  r_bcount   <= '0;
                  r_overflow <= 1'b0;
                  r_done     <= len_words == '0;
                  r_state    <= (len_words == '0) ? DONE : LOAD;
               end
            LOAD:
               if (w_accept) begin
                  // shifting in keeps the first byte of the word at the top
                  r_wdata  <= {r_wdata[23:0], byte_in};
                  r_bcount <= r_bcount + 2'd1;
                  if (r_bcount == 2'd3) begin
                     r_we    <= 1'b1;
                     r_waddr <= {r_wcount[ADDRESS_WIDTH-3:0], 2'b00};
                     r_state <= WRITE;
                  end
               end
            WRITE: begin
               r_wcount <= w_wcount_nxt;
               if (w_len_hit || w_last_addr) begin
                  r_state    <= DONE;
                  r_done     <= 1'b1;
                  r_overflow <= r_len > CAP;
               end else
                  r_state <= LOAD;
            end
            default: r_state <= IDLE;
         endcase
      end

   assign byte_ready = r_state == LOAD;
   assign busy       = (r_state == LOAD) || (r_state == WRITE);
   assign we         = r_we;
   assign waddr      = r_waddr;
   assign wdata      = r_wdata;
   assign done       = r_done;
   assign overflow   = r_overflow;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] r_checksum;

   always_ff @(posedge clk or posedge rst)
      if (rst)
         r_checksum <= '0;
      else if (w_start)
         r_checksum <= '0;
      else if (w_accept)
         r_checksum <= r_checksum + byte_in;

   assign checksum = r_checksum;
`else
   logic w_unused;

   assign w_unused = w_start;
   assign checksum = 8'h00;
`endif
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized scoreboard bench for instr_loader (large and small memory)
module tb_instr_loader;
   localparam int AW  = 10;
   localparam int AWS = 4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [7:0]    byte_in = 8'h00;
   logic          byte_valid = 1'b0;
   logic          start_a = 1'b0;
   logic          start_b = 1'b0;
   logic [AW-2:0] len_a = '0;
   logic [AWS-2:0] len_b = '0;

   logic          ready_a, we_a, busy_a, done_a, ovf_a;
   logic [AW-1:0] waddr_a;
   logic [31:0]   wdata_a;
   logic [7:0]    cks_a;
   logic          ready_b, we_b, busy_b, done_b, ovf_b;
   logic [AWS-1:0] waddr_b;
   logic [31:0]   wdata_b;
   logic [7:0]    cks_b;

   int   checks = 0;
   int   errors = 0;
   wr_t  q_a[$];
   wr_t  q_b[$];
   wr_t  e_a, e_b;
   bit   fin_a = 0;
   bit   fin_b = 0;
   logic [7:0] stim[$];

   instr_loader #(.ADDRESS_WIDTH(AW)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .len_words(len_a),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready_a),
      .we(we_a), .waddr(waddr_a), .wdata(wdata_a), .busy(busy_a),
      .done(done_a), .overflow(ovf_a), .checksum(cks_a)
   );

   instr_loader #(.ADDRESS_WIDTH(AWS)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .len_words(len_b),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(ready_b),
      .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .busy(busy_b),
      .done(done_b), .overflow(ovf_b), .checksum(cks_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk)
      if (!rst) begin
         if (fin_a) begin
            chk("done_after_last_write_a", {31'b0, done_a}, 1);
            fin_a = 0;
         end
         if (we_a) begin
            chk("ready_low_in_write_a", {31'b0, ready_a}, 0);
            if (q_a.size() == 0)
               chk("unexpected_we_a", {31'b0, we_a}, 0);
            else begin
               e_a = q_a.pop_front();
               chk("waddr_a", {22'b0, waddr_a}, e_a.addr);
               chk("wdata_a", wdata_a, e_a.data);
               fin_a = q_a.size() == 0;
            end
         end
      end

   always @(negedge clk)
      if (!rst) begin
         if (fin_b) begin
            chk("done_after_last_write_b", {31'b0, done_b}, 1);
            fin_b = 0;
         end
         if (we_b) begin
            chk("ready_low_in_write_b", {31'b0, ready_b}, 0);
            if (q_b.size() == 0)
               chk("unexpected_we_b", {31'b0, we_b}, 0);
            else begin
               e_b = q_b.pop_front();
               chk("waddr_b", {28'b0, waddr_b}, e_b.addr);
               chk("wdata_b", wdata_b, e_b.data);
               fin_b = q_b.size() == 0;
            end
         end
      end

   task automatic fill_rand(input int n);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
   endtask

   // mode 0: valid always high, 1: valid toggles 1,0, 2: random valid
   task automatic run_load(input bit sel, input int len, input int mode, input bit busy_starts);
      int   cap, n, acc, sum, t;
      bit   ok;
      logic rdy, bsy, dn;
      logic [7:0] exp_cks;
      wr_t  e;
      cap = sel ? 4 : 256;
      n   = (len < cap) ? len : cap;
      sum = 0;
      for (int k = 0; k < n; k++) begin
         e.addr = 32'(4 * k);
         e.data = {stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]};
         sum += int'(stim[4*k]) + int'(stim[4*k+1]) + int'(stim[4*k+2]) + int'(stim[4*k+3]);
         if (sel) q_b.push_back(e); else q_a.push_back(e);
      end
`ifdef LOADER_CHECKSUM_EN
      exp_cks = 8'(sum);
`else
      exp_cks = 8'h00;
`endif
      @(negedge clk);
      if (sel) begin start_b = 1; len_b = (AWS-1)'(len); end
      else begin start_a = 1; len_a = (AW-1)'(len); end
      @(negedge clk);
      start_a = 0;
      start_b = 0;
      chk("busy_after_start", {31'b0, sel ? busy_b : busy_a}, {31'b0, n != 0});
      chk("done_after_start", {31'b0, sel ? done_b : done_a}, {31'b0, n == 0});
      acc = 0;
      ok  = 0;
      t   = 0;
      while (!ok && t < 12000) begin
         start_a = 0;
         start_b = 0;
         rdy = sel ? ready_b : ready_a;
         bsy = sel ? busy_b : busy_a;
         dn  = sel ? done_b : done_a;
         if (!bsy && dn)
            ok = 1;
         else begin
            if (acc < stim.size()) begin
               byte_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ~t[0] : 1'($urandom_range(0, 1));
               byte_in    = stim[acc];
               if (byte_valid && rdy) acc++;
            end else
               byte_valid = 0;
            if (busy_starts && bsy && $urandom_range(0, 5) == 0) begin
               if (sel) begin start_b = 1; len_b = (AWS-1)'($urandom); end
               else begin start_a = 1; len_a = (AW-1)'($urandom); end
            end
            @(negedge clk);
            t++;
         end
      end
      byte_valid = 0;
      start_a = 0;
      start_b = 0;
      chk("load_completes", {31'b0, ok}, 1);
      chk("bytes_accepted", acc, 4 * n);
      chk("overflow", {31'b0, sel ? ovf_b : ovf_a}, {31'b0, len > cap});
      chk("checksum", {24'b0, sel ? cks_b : cks_a}, {24'b0, exp_cks});
      chk("writes_outstanding", sel ? q_b.size() : q_a.size(), 0);
      repeat (3) @(negedge clk);
      chk("done_holds", {31'b0, sel ? done_b : done_a}, 1);
      chk("overflow_holds", {31'b0, sel ? ovf_b : ovf_a}, {31'b0, len > cap});
   endtask

   initial begin
      #1 rst = 1;
      #2;
      chk("rst_byte_ready", {31'b0, ready_a}, 0);
      chk("rst_we", {31'b0, we_a}, 0);
      chk("rst_waddr", {22'b0, waddr_a}, 0);
      chk("rst_wdata", wdata_a, 0);
      chk("rst_busy", {31'b0, busy_a}, 0);
      chk("rst_done", {31'b0, done_a}, 0);
      chk("rst_overflow", {31'b0, ovf_a}, 0);
      chk("rst_checksum", {24'b0, cks_a}, 0);
      @(negedge clk);
      rst = 0;

      stim = '{8'h13, 8'h00, 8'h50, 8'h93, 8'h00, 8'hA0, 8'h05, 8'h13};
      run_load(0, 2, 0, 0);
      run_load(0, 2, 1, 0);
      stim.delete();
      run_load(0, 0, 0, 0);
      fill_rand(24);
      run_load(1, 6, 0, 0);
      stim = '{8'hFF, 8'h01, 8'h02, 8'h03};
      run_load(0, 1, 0, 0);

      // abort a word halfway with reset; no write may follow
      @(negedge clk);
      start_a = 1;
      len_a   = 1;
      @(negedge clk);
      start_a    = 0;
      byte_valid = 1;
      byte_in    = 8'hAA;
      @(negedge clk);
      byte_in = 8'hBB;
      @(negedge clk);
      byte_valid = 0;
      rst = 1;
      #1;
      chk("midword_rst_busy", {31'b0, busy_a}, 0);
      chk("midword_rst_ready", {31'b0, ready_a}, 0);
      chk("midword_rst_wdata", wdata_a, 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("idle_after_rst", {31'b0, busy_a}, 0);
      chk("idle_after_rst_done", {31'b0, done_a}, 0);
      fill_rand(4);
      run_load(0, 1, 0, 0);

      for (int i = 0; i < 16; i++) begin
         int len;
         len = $urandom_range(0, 40);
         fill_rand(4 * len + $urandom_range(0, 6));
         run_load(0, len, $urandom_range(0, 2), 1);
      end
      fill_rand(1200);
      run_load(0, 300, 2, 1);
      for (int i = 0; i < 12; i++) begin
         int len;
         len = $urandom_range(0, 7);
         fill_rand(4 * len + $urandom_range(0, 6));
         run_load(1, len, $urandom_range(0, 2), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
